// File: rtl/ws2812b_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ws2812b_frame_scheduler
// Purpose  : Periodic WS2812B frame sequencer; walks the colour store and hands
//            GRB words to the serializer, then holds the latch gap.
// Revision : 1.0 - initial release
// ============================================================================
module ws2812b_frame_scheduler #(
    parameter int LEDCOUNT     = 36,
    parameter int FRAME_CYCLES = 90000,
    parameter int LATCH_CYCLES = 450
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [7:0]  led_addr,
    input  logic [23:0] led_rgb,
    output logic [23:0] bitstream,
    output logic        bitstream_available,
    input  logic        bitstream_read,
    output logic        busy,
    output logic        frame_start,
    output logic        frame_done,
    output logic [7:0]  overrun_count
);

    localparam int c_TICK_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int c_LATCH_W = (LATCH_CYCLES > 0) ? $clog2(LATCH_CYCLES + 1) : 1;

    localparam logic [c_TICK_W-1:0]  c_TICK_RELOAD = c_TICK_W'(FRAME_CYCLES - 1);
    localparam logic [c_LATCH_W-1:0] c_LATCH_LOAD  = c_LATCH_W'(LATCH_CYCLES);
    localparam logic [c_LATCH_W-1:0] c_LATCH_ONE   = c_LATCH_W'(1);
    localparam logic [7:0]           c_LAST_ADDR   = 8'(LEDCOUNT - 1);
    localparam logic                 c_NO_GAP      = (LATCH_CYCLES == 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_OFFER = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;

    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic [c_LATCH_W-1:0] r_latch_cnt;
    logic [2:0]           r_state;

    logic                 w_tick;
    logic                 w_last_led;
    logic [2:0]           w_state_nxt;
    logic [7:0]           w_addr_nxt;
    logic [23:0]          w_bits_nxt;
    logic                 w_avail_nxt;
    logic                 w_start_nxt;
    logic                 w_done_nxt;
    logic [c_LATCH_W-1:0] w_latch_nxt;
    logic [7:0]           w_overrun_nxt;

    assign w_tick     = (r_tick_cnt == '0);
    assign w_last_led = (led_addr >= c_LAST_ADDR);

    // Free-running frame tick, independent of enable and FSM state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= c_TICK_RELOAD;
        end else if (w_tick) begin
            r_tick_cnt <= c_TICK_RELOAD;
        end else begin
            r_tick_cnt <= r_tick_cnt - 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state             <= S_IDLE;
            r_latch_cnt         <= '0;
            led_addr            <= 8'd0;
            bitstream           <= 24'd0;
            bitstream_available <= 1'b0;
            busy                <= 1'b0;
            frame_start         <= 1'b0;
            frame_done          <= 1'b0;
            overrun_count       <= 8'd0;
        end else begin
            r_state             <= w_state_nxt;
            r_latch_cnt         <= w_latch_nxt;
            led_addr            <= w_addr_nxt;
            bitstream           <= w_bits_nxt;
            bitstream_available <= w_avail_nxt;
            busy                <= (w_state_nxt != S_IDLE);
            frame_start         <= w_start_nxt;
            frame_done          <= w_done_nxt;
            overrun_count       <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tick && enable) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_OFFER;
            S_OFFER: begin
                if (bitstream_read) begin
                    if (!w_last_led) begin
                        w_state_nxt = S_FETCH;
                    end else if (c_NO_GAP) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_LATCH;
                    end
                end
            end
            S_LATCH: if (r_latch_cnt <= c_LATCH_ONE) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_addr_nxt  = led_addr;
        w_bits_nxt  = bitstream;
        w_avail_nxt = bitstream_available;
        w_latch_nxt = r_latch_cnt;
        w_start_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick && enable) begin
                    w_addr_nxt  = 8'd0;
                    w_start_nxt = 1'b1;
                end
            end
            S_LOAD: begin
                // Store delivers {R,G,B}; the serializer wants {G,R,B}.
                w_bits_nxt  = {led_rgb[15:8], led_rgb[23:16], led_rgb[7:0]};
                w_avail_nxt = 1'b1;
            end
            S_OFFER: begin
                if (bitstream_read) begin
                    w_avail_nxt = 1'b0;
                    if (w_last_led) begin
                        w_latch_nxt = c_LATCH_LOAD;
                        w_done_nxt  = c_NO_GAP;
                    end else begin
                        w_addr_nxt = led_addr + 8'd1;
                    end
                end
            end
            S_LATCH: begin
                w_avail_nxt = 1'b0;
                w_latch_nxt = r_latch_cnt - 1'b1;
                if (r_latch_cnt <= c_LATCH_ONE) w_done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // A tick that lands while not idle is dropped and counted, saturating.
    always_comb begin
        w_overrun_nxt = overrun_count;
        if (w_tick && (r_state != S_IDLE) && (overrun_count != 8'hFF)) begin
            w_overrun_nxt = overrun_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_frame_scheduler.sv
`default_nettype none
// Bench: two scheduler rigs (200-cycle frame with latch gap, 40-cycle frame with no
// gap) checked against frame event times computed from tick/delay arithmetic.
module tb_ws2812b_frame_scheduler;

    localparam int c_N   = 3;
    localparam int c_F0  = 200;
    localparam int c_L0  = 10;
    localparam int c_F1  = 40;
    localparam int c_L1  = 0;
    localparam int c_LOG = 1024;
    localparam int c_BIG = 1 << 30;

    logic        clk;
    logic        rst_v [2];
    logic        en_v  [2];
    logic        av_v  [2];
    logic        rd_v  [2];
    logic        busy_v[2];
    logic        fs_v  [2];
    logic        fd_v  [2];
    logic [7:0]  addr_v[2];
    logic [7:0]  ov_v  [2];
    logic [23:0] rgb_v [2];
    logic [23:0] bs_v  [2];

    logic [23:0] store[2][c_N];
    int          cyc = 0;
    int          base[2];
    int          delay[2];
    int          en_off[2];
    int          avcnt[2];
    int          addr_bad[2];
    int          spur_at[2][$];
    int          q_start[2][$];
    int          q_done[2][$];
    int          q_rc[2][$];
    logic [23:0] q_word[2][$];
    logic [7:0]  addr_log[2][c_LOG];
    logic        busy_log[2][c_LOG];
    int          n_assert;
    int          n_fail;

    ws2812b_frame_scheduler #(.LEDCOUNT(c_N), .FRAME_CYCLES(c_F0), .LATCH_CYCLES(c_L0)) u_dut0 (
        .clk(clk), .reset(rst_v[0]), .enable(en_v[0]), .led_addr(addr_v[0]), .led_rgb(rgb_v[0]),
        .bitstream(bs_v[0]), .bitstream_available(av_v[0]), .bitstream_read(rd_v[0]),
        .busy(busy_v[0]), .frame_start(fs_v[0]), .frame_done(fd_v[0]), .overrun_count(ov_v[0]));

    ws2812b_frame_scheduler #(.LEDCOUNT(c_N), .FRAME_CYCLES(c_F1), .LATCH_CYCLES(c_L1)) u_dut1 (
        .clk(clk), .reset(rst_v[1]), .enable(en_v[1]), .led_addr(addr_v[1]), .led_rgb(rgb_v[1]),
        .bitstream(bs_v[1]), .bitstream_available(av_v[1]), .bitstream_read(rd_v[1]),
        .busy(busy_v[1]), .frame_start(fs_v[1]), .frame_done(fd_v[1]), .overrun_count(ov_v[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Colour store: data valid one cycle after the address.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            rgb_v[g] <= (int'(addr_v[g]) < c_N) ? store[g][int'(addr_v[g])] : 24'h0;
        end
    end

    // Serializer model, enable drive and event logging, all away from the active edge.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            int   rel;
            logic sp;
            rel = cyc - base[g];
            sp  = 1'b0;
            if (rel >= 0 && rel < c_LOG) begin
                addr_log[g][rel] = addr_v[g];
                busy_log[g][rel] = busy_v[g];
            end
            if (fs_v[g]) q_start[g].push_back(rel);
            if (fd_v[g]) q_done[g].push_back(rel);
            if (int'(addr_v[g]) >= c_N) addr_bad[g]++;
            avcnt[g] = av_v[g] ? avcnt[g] + 1 : 0;
            for (int k = 0; k < spur_at[g].size(); k++) begin
                if (spur_at[g][k] == rel) sp = 1'b1;
            end
            if (av_v[g] && avcnt[g] == delay[g] + 1) begin
                q_rc[g].push_back(rel);
                q_word[g].push_back(bs_v[g]);
                sp = 1'b1;
            end
            rd_v[g] = sp;
            en_v[g] = (rel < en_off[g]);
        end
    end

    function automatic logic [23:0] grb(input logic [23:0] c);
        return {c[15:8], c[23:16], c[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Releases reset for rig g just after a falling edge; that cycle is rel 0.
    task automatic begin_phase(input int g, input int d, input int eoff);
        @(negedge clk);
        #1;
        q_start[g].delete();
        q_done[g].delete();
        q_rc[g].delete();
        q_word[g].delete();
        delay[g]  = d;
        en_off[g] = eoff;
        avcnt[g]  = 0;
        base[g]   = cyc;
        rst_v[g]  = 1'b0;
    endtask

    // Runs rig g through rel E, then compares logged events against the frame model
    // and re-asserts reset.
    task automatic run_check(input int g, input int E);
        int f, l, d, done_at, ov, r, got;
        int e_start[$], e_done[$], e_rc[$];
        logic [23:0] e_w[$];
        logic [23:0] gw;
        do begin
            @(posedge clk);
            #1;
        end while (cyc - base[g] < E + 1);
        f = (g == 0) ? c_F0 : c_F1;
        l = (g == 0) ? c_L0 : c_L1;
        d = delay[g];
        done_at = 0;
        ov = 0;
        r = 0;
        for (int tc = f - 1; tc <= E; tc += f) begin
            if (tc < done_at) begin
                ov++;
            end else if (tc < en_off[g]) begin
                e_start.push_back(tc + 1);
                for (int i = 0; i < c_N; i++) begin
                    r = tc + (i + 1) * (3 + d);
                    e_rc.push_back(r);
                    e_w.push_back(grb(store[g][i]));
                end
                done_at = r + l + 1;
                e_done.push_back(done_at);
            end
        end
        for (int i = 0; i < e_start.size(); i++) begin
            if (e_start[i] <= E) begin
                got = -1;
                if (q_start[g].size() > 0) got = q_start[g].pop_front();
                chk("frame_start_cycle", got, e_start[i]);
            end
        end
        for (int i = 0; i < e_rc.size(); i++) begin
            if (e_rc[i] <= E) begin
                got = -1;
                gw  = 24'hxxxxxx;
                if (q_rc[g].size() > 0) begin
                    got = q_rc[g].pop_front();
                    gw  = q_word[g].pop_front();
                end
                chk("read_cycle", got, e_rc[i]);
                chk("bitstream_word", gw, e_w[i]);
            end
        end
        for (int i = 0; i < e_done.size(); i++) begin
            if (e_done[i] <= E) begin
                got = -1;
                if (q_done[g].size() > 0) got = q_done[g].pop_front();
                chk("frame_done_cycle", got, e_done[i]);
            end
        end
        chk("extra_events", q_start[g].size() + q_done[g].size() + q_rc[g].size(), 0);
        chk("overrun_count", ov_v[g], (ov > 255) ? 255 : ov);
        rst_v[g] = 1'b1;
        spur_at[g].delete();
    endtask

    initial begin
        int bcnt;
        n_assert = 0;
        n_fail   = 0;
        for (int g = 0; g < 2; g++) begin
            rst_v[g]    = 1'b1;
            base[g]     = 0;
            delay[g]    = 5;
            en_off[g]   = c_BIG;
            avcnt[g]    = 0;
            addr_bad[g] = 0;
            store[g][0] = 24'h112233;
            store[g][1] = 24'h445566;
            store[g][2] = 24'h778899;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_led_addr", addr_v[0], 8'd0);
        chk("rst_bitstream", bs_v[0], 24'd0);
        chk("rst_available", av_v[0], 1'b0);
        chk("rst_busy", busy_v[0], 1'b0);
        chk("rst_frame_start", fs_v[0], 1'b0);
        chk("rst_frame_done", fd_v[0], 1'b0);
        chk("rst_overrun", ov_v[0], 8'd0);

        // Normal frame with stray reads in IDLE, FETCH (LED0, LED1) and LATCH.
        spur_at[0] = '{100, 200, 208, 226};
        begin_phase(0, 5, c_BIG);
        run_check(0, 390);
        chk("busy_at_tick", busy_log[0][199], 1'b0);
        chk("busy_after_tick", busy_log[0][200], 1'b1);
        chk("addr_frame_start", addr_log[0][200], 8'd0);
        chk("spur_idle_addr", addr_log[0][101], 8'd0);
        chk("spur_idle_busy", busy_log[0][101], 1'b0);
        chk("spur_fetch0_addr", addr_log[0][201], 8'd0);
        chk("spur_fetch1_addr", addr_log[0][209], 8'd1);
        chk("spur_latch_addr", addr_log[0][227], 8'd2);
        chk("spur_latch_busy", busy_log[0][227], 1'b1);
        chk("busy_before_done", busy_log[0][233], 1'b1);
        chk("busy_at_done", busy_log[0][234], 1'b0);

        // Random colours and serializer delays over three frames.
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < c_N; i++) store[0][i] = 24'($urandom);
            begin_phase(0, int'($urandom_range(1, 20)), c_BIG);
            run_check(0, 719);
        end

        // Enable low across two ticks: nothing starts, nothing counted.
        begin_phase(0, 5, 0);
        run_check(0, 450);
        bcnt = 0;
        for (int i = 0; i <= 450; i++) bcnt += int'(busy_log[0][i]);
        chk("busy_while_disabled", bcnt, 0);

        // Enable dropped right after the first read: frame completes, no more frames.
        begin_phase(0, 5, 208);
        run_check(0, 799);

        // Asynchronous reset while offering LED 1.
        begin_phase(0, 5, c_BIG);
        do @(negedge clk); while (cyc - base[0] < 212);
        #1;
        chk("pre_reset_available", av_v[0], 1'b1);
        chk("pre_reset_addr", addr_v[0], 8'd1);
        rst_v[0] = 1'b1;
        #1;
        chk("async_rst_available", av_v[0], 1'b0);
        chk("async_rst_busy", busy_v[0], 1'b0);
        chk("async_rst_addr", addr_v[0], 8'd0);
        begin_phase(0, 5, c_BIG);
        run_check(0, 300);
        chk("restart_addr", addr_log[0][200], 8'd0);

        // Short frames, zero latch gap: one dropped tick per frame.
        begin_phase(1, 20, c_BIG);
        run_check(1, 299);
        chk("nogap_busy_at_read", busy_log[1][108], 1'b1);
        chk("nogap_busy_after_read", busy_log[1][109], 1'b0);

        for (int i = 0; i < c_N; i++) store[1][i] = 24'($urandom);
        begin_phase(1, int'($urandom_range(1, 40)), c_BIG);
        run_check(1, 500);

        // Serializer stalls: more than 255 dropped ticks saturate the count.
        begin_phase(1, 1000000, c_BIG);
        run_check(1, 12079);

        chk("addr_in_range_rig0", addr_bad[0], 0);
        chk("addr_in_range_rig1", addr_bad[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
